// File: rtl/conv_result_collector.sv
// conv_result_collector
// Tags the convolution core's result stream with line/frame markers, buffers
// it in a show-ahead FIFO and hands it downstream over a ready/valid port.
//
// Handshake: downstream sees a result when m_valid=1; it is consumed on a
// rising edge where m_valid && m_ready. m_data/flags hold while m_valid &&
// !m_ready. The upstream side (valid_in) has no backpressure: results that
// cannot be stored are dropped and reported through the sticky overflow flag.
module conv_result_collector #(
   parameter int PIXEL_WIDTH        = 8,
   parameter int KERNEL_ROW_SIZE    = 3,
   parameter int KERNEL_COLUMN_SIZE = 3,
   parameter int BUFFER_LENGTH      = 2000,
   parameter int FIFO_DEPTH         = 16,
   localparam int CW                = $clog2(BUFFER_LENGTH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [CW-1:0]          frame_column_size,
   input  logic [CW-1:0]          frame_row_size,
   input  logic [PIXEL_WIDTH-1:0] conv_res,
   input  logic                   valid_in,
   output logic [PIXEL_WIDTH-1:0] m_data,
   output logic                   m_sol,
   output logic                   m_eol,
   output logic                   m_eof,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic                   busy,
   output logic                   frame_done,
   output logic                   cfg_err,
   output logic                   overflow,
   output logic [1:0]             dbg_state
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = PIXEL_WIDTH + 3;
   localparam logic [CW-1:0] KC = CW'(KERNEL_COLUMN_SIZE);
   localparam logic [CW-1:0] KR = CW'(KERNEL_ROW_SIZE);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_DRAIN   = 2'd2
   } state_t;

   state_t          r_state, w_state_next;
   logic [CW-1:0]   r_last_col, r_last_row;   // OC-1 and OR-1
   logic [CW-1:0]   r_col, r_row;
   logic [AW:0]     r_wp, r_rp, w_count;
   logic [EW-1:0]   r_mem [FIFO_DEPTH];
   logic [EW-1:0]   w_head;
   logic            r_frame_done, r_cfg_err, r_overflow;
   logic            w_empty, w_full, w_push, w_pop;
   logic            w_sol, w_eol, w_eof, w_in_collect;
   logic            w_start_ok, w_start_bad, w_drain_done;

   assign w_count      = r_wp - r_rp;
   assign w_empty      = (r_wp == r_rp);
   assign w_full       = (w_count == (AW+1)'(FIFO_DEPTH));
   assign w_pop        = !w_empty && m_ready;
   assign w_in_collect = (r_state == S_COLLECT);
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_push       = valid_in && w_in_collect && (!w_full || w_pop);

   assign w_sol = (r_col == '0);
   assign w_eol = (r_col == r_last_col);
   assign w_eof = w_eol && (r_row == r_last_row);

   assign w_start_ok  = (r_state == S_IDLE) && start &&
                        (frame_column_size >= KC) && (frame_row_size >= KR);
   assign w_start_bad = (r_state == S_IDLE) && start && !w_start_ok;
   // Nothing is pushed while draining, so the FIFO is empty after this edge
   // when it holds nothing, or only the entry being popped now.
   assign w_drain_done = (w_count == {{AW{1'b0}}, w_pop});

   // Next-state logic for the frame sequencer.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:    if (w_start_ok) w_state_next = S_COLLECT;
         S_COLLECT: if (valid_in && w_eof) w_state_next = S_DRAIN;
         S_DRAIN:   if (w_drain_done) w_state_next = S_IDLE;
         default:   w_state_next = S_IDLE;
      endcase
   end

   // State register and the one-cycle status pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_frame_done <= 1'b0;
         r_cfg_err    <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_frame_done <= (r_state == S_DRAIN) && w_drain_done;
         r_cfg_err    <= w_start_bad;
      end
   end

   // Geometry latch and raster position counters; counters advance on every
   // result in COLLECT, stored or dropped, so tagging stays aligned.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_col <= '0;
         r_last_row <= '0;
         r_col      <= '0;
         r_row      <= '0;
      end else if (w_start_ok) begin
         r_last_col <= frame_column_size - KC;
         r_last_row <= frame_row_size - KR;
         r_col      <= '0;
         r_row      <= '0;
      end else if (w_in_collect && valid_in) begin
         if (w_eol) begin
            r_col <= '0;
            r_row <= r_row + CW'(1);
         end else begin
            r_col <= r_col + CW'(1);
         end
      end
   end

   // Sticky loss flag: set by dropped or stray results, cleared by a new frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overflow <= 1'b0;
      end else if (w_start_ok) begin
         r_overflow <= 1'b0;
      end else if (valid_in && !w_push) begin
         r_overflow <= 1'b1;
      end
   end

   // FIFO pointers; the extra MSB separates full from empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wp <= '0;
         r_rp <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + (AW+1)'(1);
         if (w_pop)  r_rp <= r_rp + (AW+1)'(1);
      end
   end

   // FIFO storage; contents are don't-care until written, outputs are gated.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp[AW-1:0]] <= {w_eof, w_eol, w_sol, conv_res};
   end

   assign w_head     = w_empty ? '0 : r_mem[r_rp[AW-1:0]];
   assign m_data     = w_head[PIXEL_WIDTH-1:0];
   assign m_sol      = w_head[PIXEL_WIDTH];
   assign m_eol      = w_head[PIXEL_WIDTH+1];
   assign m_eof      = w_head[PIXEL_WIDTH+2];
   assign m_valid    = !w_empty;
   assign busy       = (r_state != S_IDLE);
   assign frame_done = r_frame_done;
   assign cfg_err    = r_cfg_err;
   assign overflow   = r_overflow;
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_conv_result_collector.sv
// Testbench for conv_result_collector: directed frame scenarios with random
// data, checked cycle by cycle against a frame-level queue model.
module tb_conv_result_collector;

  localparam int PW = 8;
  localparam int CW = 11;
  localparam int FD = 16;
  localparam int EW = PW + 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] frame_column_size = '0;
  logic [CW-1:0] frame_row_size = '0;
  logic [PW-1:0] conv_res = '0;
  logic          valid_in = 1'b0;
  logic [PW-1:0] m_data;
  logic          m_sol, m_eol, m_eof, m_valid;
  logic          m_ready = 1'b0;
  logic          busy, frame_done, cfg_err, overflow;
  logic [1:0]    dbg_state;

  conv_result_collector #(
    .PIXEL_WIDTH(PW), .KERNEL_ROW_SIZE(3), .KERNEL_COLUMN_SIZE(3),
    .BUFFER_LENGTH(2000), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .frame_column_size(frame_column_size), .frame_row_size(frame_row_size),
    .conv_res(conv_res), .valid_in(valid_in),
    .m_data(m_data), .m_sol(m_sol), .m_eol(m_eol), .m_eof(m_eof),
    .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err),
    .overflow(overflow), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // scoreboard / reference model
  logic [EW-1:0] exp_q[$];
  int  total = 0;
  int  bad = 0;
  bit  md_collect = 0, md_drain = 0, md_ovf = 0;
  bit  exp_fd = 0, exp_cfg = 0;
  int  md_k = 0, md_oc = 1, md_or = 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [31:0] exp_out;
    exp_out = (exp_q.size() == 0) ? 32'd0 : {20'd0, 1'b1, exp_q[0]};
    check("head", {20'd0, m_valid, m_eof, m_eol, m_sol, m_data}, exp_out);
    check("busy", {31'd0, busy}, {31'd0, md_collect | md_drain});
    check("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
    check("cfg_err", {31'd0, cfg_err}, {31'd0, exp_cfg});
    check("overflow", {31'd0, overflow}, {31'd0, md_ovf});
  endtask

  // One clock cycle: drive inputs at the falling edge, check, advance model.
  task automatic step(input bit st, input int cols, input int rows,
                      input bit vin, input logic [PW-1:0] d, input bit rdy);
    bit pop, full_before, was_drain, was_collect, idle;
    bit sol, eol, eof;
    int col, row;
    start = st; frame_column_size = CW'(cols); frame_row_size = CW'(rows);
    valid_in = vin; conv_res = d; m_ready = rdy;
    #1;
    check_outputs();
    full_before = (exp_q.size() >= FD);
    pop = (exp_q.size() > 0) && rdy;
    was_drain = md_drain; was_collect = md_collect;
    idle = !md_collect && !md_drain;
    exp_fd = 0; exp_cfg = 0;
    if (pop) void'(exp_q.pop_front());
    if (was_collect && vin) begin
      col = md_k % md_oc;
      row = md_k / md_oc;
      sol = (col == 0);
      eol = (col == md_oc - 1);
      eof = eol && (row == md_or - 1);
      if (!full_before || pop) exp_q.push_back({eof, eol, sol, d});
      else md_ovf = 1;
      md_k++;
      if (eof) begin md_collect = 0; md_drain = 1; end
    end else if (vin) begin
      md_ovf = 1;
    end
    if (was_drain && exp_q.size() == 0) begin md_drain = 0; exp_fd = 1; end
    if (idle && st) begin
      if (cols < 3 || rows < 3) exp_cfg = 1;
      else begin
        md_collect = 1; md_k = 0; md_oc = cols - 2; md_or = rows - 2; md_ovf = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_step(input bit rdy);
    step(0, 0, 0, 0, '0, rdy);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (md_drain || md_collect || exp_fd); i++) idle_step(1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 0; valid_in = 0; m_ready = 0; conv_res = '0;
    #1;
    exp_q.delete();
    md_collect = 0; md_drain = 0; md_ovf = 0; exp_fd = 0; exp_cfg = 0; md_k = 0;
    check_outputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_step(0);
  endtask

  // Random frame: random data, optional gaps, ready random or held high,
  // and occasional start pulses that must be ignored while busy.
  task automatic run_frame(input int cols, input int rows, input bit rand_rdy);
    int n;
    step(1, cols, rows, 0, '0, 1);
    n = (cols - 2) * (rows - 2);
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 3) == 0)
        idle_step(rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
      step(($urandom_range(0, 7) == 0), 6, 6, 1, PW'($urandom),
           rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
    end
    drain();
  endtask

  initial begin
    do_reset();

    // 5x4 frame, ready high, data 1..6
    step(1, 5, 4, 0, '0, 1);
    for (int i = 1; i <= 6; i++) step(0, 0, 0, 1, PW'(i), 1);
    drain();

    // backpressure: ten stalled cycles then drain
    step(1, 5, 4, 0, '0, 0);
    for (int i = 1; i <= 6; i++) step(0, 0, 0, 1, PW'(i), 0);
    for (int i = 0; i < 4; i++) idle_step(0);
    drain();

    // exact fill (OC=16), no overflow
    step(1, 18, 3, 0, '0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, PW'($urandom), 0);
    idle_step(0);
    drain();

    // overfill (OC=18): last two dropped, overflow set
    step(1, 20, 3, 0, '0, 0);
    for (int i = 0; i < 18; i++) step(0, 0, 0, 1, PW'($urandom), 0);
    drain();
    idle_step(1);

    // next accepted start clears overflow
    run_frame(5, 4, 1'b0);

    // rejected configurations and stray input
    step(1, 2, 4, 0, '0, 1);
    idle_step(1);
    step(1, 5, 1, 0, '0, 1);
    idle_step(1);
    step(0, 0, 0, 1, 8'h5a, 1);
    idle_step(1);

    // simultaneous push/pop on a full FIFO
    step(1, 20, 3, 0, '0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, PW'($urandom), 0);
    step(0, 0, 0, 1, PW'($urandom), 1);
    step(0, 0, 0, 1, PW'($urandom), 1);
    drain();

    // reset in the middle of a frame, then a clean frame
    step(1, 5, 4, 0, '0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, PW'($urandom), 0);
    do_reset();
    run_frame(5, 4, 1'b0);

    // random geometries with random ready
    for (int f = 0; f < 6; f++)
      run_frame($urandom_range(3, 9), $urandom_range(3, 5), 1'b1);
    idle_step(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
